// File: rtl/tx_sample_upconverter.sv
// Widens signed baseband samples to OUT_W bits with a saturating left-shift gain and
// emits RATE outputs per input (hold or zero-stuff) towards the CIC interpolator.
module tx_sample_upconverter #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 53,
    parameter int SHIFT_W = 6,
    parameter int RATE_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic signed [IN_W-1:0]  in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SHIFT_W-1:0]      shift_i,
    input  logic [RATE_W-1:0]       rate_i,
    input  logic                    zstuff_i,
    output logic signed [OUT_W-1:0] out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    sat_o,
    input  logic                    sat_clr_i
);

    // Wide enough to hold any input shifted by the largest gain without losing bits.
    localparam int FULL_W = IN_W + (2**SHIFT_W) - 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [RATE_W-1:0]        count;
    logic                     zmode;
    logic signed [OUT_W-1:0]  data;
    logic                     sat;

    logic                     accept;
    logic                     transfer;
    logic                     last;
    logic signed [FULL_W-1:0] ext;
    logic signed [FULL_W-1:0] shifted;
    logic [FULL_W-OUT_W:0]    upper;
    logic                     ovf;
    logic signed [OUT_W-1:0]  widened;
    logic [RATE_W-1:0]        rate_eff;

    // Exact result fits only if every bit from the OUT_W sign position upward agrees.
    always_comb begin
        ext      = {{(FULL_W-IN_W){in_data_i[IN_W-1]}}, in_data_i};
        shifted  = ext <<< shift_i;
        upper    = shifted[FULL_W-1:OUT_W-1];
        ovf      = !((&upper) || (~|upper));
        if (!ovf)
            widened = shifted[OUT_W-1:0];
        else if (shifted[FULL_W-1])
            widened = {1'b1, {(OUT_W-1){1'b0}}};
        else
            widened = {1'b0, {(OUT_W-1){1'b1}}};
        rate_eff = (rate_i == '0) ? RATE_W'(1) : rate_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EMIT;
            EMIT: if (transfer && last) state_next = accept ? EMIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last        = (count == RATE_W'(1));
        out_valid_o = (state == EMIT);
        in_ready_o  = (state == IDLE) || (last && out_ready_i);
        accept      = in_valid_i && in_ready_o;
        transfer    = out_valid_o && out_ready_i;
        out_data_o  = data;
        sat_o       = sat;
    end

    // The held register doubles as the output: hold mode keeps it, zero-stuff clears it
    // after the first transfer of a burst.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count <= '0;
            zmode <= 1'b0;
            data  <= '0;
            sat   <= 1'b0;
        end else begin
            if (accept) begin
                data  <= widened;
                count <= rate_eff;
                zmode <= zstuff_i;
            end else if (transfer) begin
                count <= count - RATE_W'(1);
                if (zmode)
                    data <= '0;
            end
            if (accept && ovf)
                sat <= 1'b1;
            else if (sat_clr_i)
                sat <= 1'b0;
        end
    end

endmodule
